// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// Pipeline MEM stage. Consumes the execute-stage outputs, runs one req/ack
// data-RAM transaction per load/store, aligns and extends load data and
// registers the result toward write-back. Upstream is stalled while a RAM
// transaction is outstanding.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   mem_read_flag            instruction is a load
//   mem_write_flag           instruction is a store
//   mem_sign_ext_flag        sign-extend load data (0 = zero-extend)
//   mem_sel[3:0]             size mask, lane-0 form (0001/0011/1111)
//   mem_write_data[31:0]     right-aligned store data
//   result[31:0]             ALU result / byte address
//   reg_write_en             instruction writes the register file
//   reg_write_addr[4:0]      destination register
//   current_pc_addr[31:0]    instruction PC
//   ram_req/ram_we/ram_addr/ram_write_data   RAM request side
//   ram_ack/ram_read_data    RAM response side
//   mem_stall                combinational upstream hold
//   mem_error                one-cycle pulse: misaligned or timed-out access
//   wb_result/wb_reg_write_en/wb_reg_write_addr/wb_pc   registered WB outputs
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_flag,
  input  logic        mem_write_flag,
  input  logic        mem_sign_ext_flag,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] result,
  input  logic        reg_write_en,
  input  logic [4:0]  reg_write_addr,
  input  logic [31:0] current_pc_addr,
  output logic        ram_req,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic        ram_ack,
  input  logic [31:0] ram_read_data,
  output logic        mem_stall,
  output logic        mem_error,
  output logic [31:0] wb_result,
  output logic        wb_reg_write_en,
  output logic [4:0]  wb_reg_write_addr,
  output logic [31:0] wb_pc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Last counter value before the access is abandoned.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic        ram_req_q;
  logic [3:0]  ram_we_q;
  logic [31:0] ram_addr_q;
  logic [31:0] ram_wdata_q;
  logic        sign_ext_q;
  logic [1:0]  lane_q;
  logic [3:0]  mask_q;
  logic        is_load_q;
  logic        rwe_q;
  logic [4:0]  rwa_q;
  logic [31:0] pc_q;
  logic        mem_error_q;
  logic [31:0] wb_result_q;
  logic        wb_we_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_pc_q;

  logic        mem_op_s;
  logic        is_load_s;
  logic [1:0]  lane_s;
  logic        misaligned_s;
  logic        timeout_s;
  logic [7:0]  we_wide_s;
  logic [3:0]  ram_we_s;
  logic        mem_stall_s;

  // Replicate right-aligned store data across every lane it may land in.
  function automatic logic [31:0] replicate_store(input logic [3:0] mask,
                                                  input logic [31:0] data);
    logic [31:0] r;
    case (mask)
      4'b0001: r = {4{data[7:0]}};
      4'b0011: r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] format_load(input logic [31:0] rd,
                                              input logic [1:0]  lane,
                                              input logic [3:0]  mask,
                                              input logic        sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{lane, 3'b000} +: 8];
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (mask)
      4'b1111: r = rd;
      4'b0011: r = {{16{sx & h[15]}}, h};
      default: r = {{24{sx & b[7]}}, b};
    endcase
    return r;
  endfunction

  assign mem_op_s     = mem_read_flag | mem_write_flag;
  // A store flag takes precedence; only a pure read is treated as a load.
  assign is_load_s    = mem_read_flag & ~mem_write_flag;
  assign lane_s       = result[1:0];
  assign misaligned_s = ((mem_sel == 4'b0011) && lane_s[0]) ||
                        ((mem_sel == 4'b1111) && (lane_s != 2'b00));
  // ack on the final cycle still completes the access.
  assign timeout_s    = ~ram_ack && (cnt_q == CNT_LAST);
  assign we_wide_s    = {4'b0000, mem_sel} << lane_s;
  assign ram_we_s     = mem_write_flag ? we_wide_s[3:0] : 4'b0000;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op_s && !misaligned_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (ram_ack || timeout_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Upstream stall: aligned memory op waiting to launch, or RAM outstanding.
  always_comb begin
    mem_stall_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op_s && !misaligned_s) begin
          mem_stall_s = 1'b1;
        end else begin
          mem_stall_s = 1'b0;
        end
      end
      ST_BUSY: mem_stall_s = 1'b1;
      ST_DONE: mem_stall_s = 1'b0;
      default: mem_stall_s = 1'b0;
    endcase
  end

  // Datapath: RAM request registers, timeout counter, error pulse, WB outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 4'b0000;
      ram_addr_q  <= 32'h0000_0000;
      ram_wdata_q <= 32'h0000_0000;
      sign_ext_q  <= 1'b0;
      lane_q      <= 2'b00;
      mask_q      <= 4'b0000;
      is_load_q   <= 1'b0;
      rwe_q       <= 1'b0;
      rwa_q       <= 5'd0;
      pc_q        <= 32'h0000_0000;
      mem_error_q <= 1'b0;
      wb_result_q <= 32'h0000_0000;
      wb_we_q     <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_pc_q     <= 32'h0000_0000;
    end else begin
      mem_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!mem_op_s) begin
            wb_result_q <= result;
            wb_we_q     <= reg_write_en;
            wb_addr_q   <= reg_write_addr;
            wb_pc_q     <= current_pc_addr;
          end else if (misaligned_s) begin
            // Dropped instruction: flag it and write nothing.
            mem_error_q <= 1'b1;
            wb_we_q     <= 1'b0;
          end else begin
            ram_req_q   <= 1'b1;
            ram_we_q    <= ram_we_s;
            ram_addr_q  <= {result[31:2], 2'b00};
            ram_wdata_q <= replicate_store(mem_sel, mem_write_data);
            sign_ext_q  <= mem_sign_ext_flag;
            lane_q      <= lane_s;
            mask_q      <= mem_sel;
            is_load_q   <= is_load_s;
            rwe_q       <= reg_write_en;
            rwa_q       <= reg_write_addr;
            pc_q        <= current_pc_addr;
            cnt_q       <= '0;
            wb_we_q     <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (ram_ack) begin
            ram_req_q   <= 1'b0;
            cnt_q       <= '0;
            wb_result_q <= format_load(ram_read_data, lane_q, mask_q, sign_ext_q);
            wb_we_q     <= is_load_q & rwe_q;
            wb_addr_q   <= rwa_q;
            wb_pc_q     <= pc_q;
          end else if (timeout_s) begin
            ram_req_q   <= 1'b0;
            cnt_q       <= '0;
            mem_error_q <= 1'b1;
            wb_we_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          // Inputs still show the instruction that just completed.
          wb_we_q <= 1'b0;
        end
        default: begin
          ram_req_q <= 1'b0;
          wb_we_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ram_req           = ram_req_q;
  assign ram_we            = ram_we_q;
  assign ram_addr          = ram_addr_q;
  assign ram_write_data    = ram_wdata_q;
  assign mem_stall         = mem_stall_s;
  assign mem_error         = mem_error_q;
  assign wb_result         = wb_result_q;
  assign wb_reg_write_en   = wb_we_q;
  assign wb_reg_write_addr = wb_addr_q;
  assign wb_pc             = wb_pc_q;

endmodule
